// File: rtl/tpg_pkg.sv
// Shared types and constants for the test-pattern video timing sequencer.
package tpg_pkg;

    localparam int TPG_H_BITS = 12;
    localparam int TPG_V_BITS = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } tpg_state_e;

    // Field positions inside cfg_h/cfg_v, counted in whole fields from the LSB.
    localparam int FLD_END        = 0;
    localparam int FLD_ACT_END    = 1;
    localparam int FLD_ACT_START  = 2;
    localparam int FLD_SYNC_END   = 3;
    localparam int FLD_SYNC_START = 4;

    typedef struct packed {
        logic [TPG_H_BITS-1:0] syncStart;
        logic [TPG_H_BITS-1:0] syncEnd;
        logic [TPG_H_BITS-1:0] actStart;
        logic [TPG_H_BITS-1:0] actEnd;
        logic [TPG_H_BITS-1:0] axisEnd;
    } h_timing_t;

    typedef struct packed {
        logic [TPG_V_BITS-1:0] syncStart;
        logic [TPG_V_BITS-1:0] syncEnd;
        logic [TPG_V_BITS-1:0] actStart;
        logic [TPG_V_BITS-1:0] actEnd;
        logic [TPG_V_BITS-1:0] axisEnd;
    } v_timing_t;

endpackage

// File: rtl/tpg_timing_ctrl_if.sv
// Config handshake, run control and video timing outputs of the sequencer.
interface tpg_timing_ctrl_if
    import tpg_pkg::*;
#(
    parameter int H_BITS = TPG_H_BITS,
    parameter int V_BITS = TPG_V_BITS
);
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [5*H_BITS-1:0] cfg_h;
    logic [5*V_BITS-1:0] cfg_v;
    logic                busy;
    logic [H_BITS-1:0]   x;
    logic [V_BITS-1:0]   y;
    logic                hs;
    logic                vs;
    logic                de;
    logic                sof;
    logic                eol;

    modport master (
        output enable, cfg_valid, cfg_h, cfg_v,
        input  cfg_ready, busy, x, y, hs, vs, de, sof, eol
    );

    modport slave (
        input  enable, cfg_valid, cfg_h, cfg_v,
        output cfg_ready, busy, x, y, hs, vs, de, sof, eol
    );
endinterface

// File: rtl/tpg_axis_cnt.sv
// One timing axis: position counter with wrap detect and sync/active window
// compares evaluated on the next count so registered strobes line up with it.
module tpg_axis_cnt
    import tpg_pkg::*;
#(
    parameter int W = TPG_H_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         step,
    input  logic [W-1:0] endCur,
    input  logic [W-1:0] syncStart,
    input  logic [W-1:0] syncEnd,
    input  logic [W-1:0] actStart,
    input  logic [W-1:0] actEnd,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cntNext,
    output logic         atEnd,
    output logic         syncNext,
    output logic         actNext
);
    // Half-open window; an empty or inverted window never matches.
    function automatic logic inWindow(input logic [W-1:0] v,
                                      input logic [W-1:0] lo,
                                      input logic [W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    assign atEnd = (cnt == endCur);

    always_comb begin
        cntNext = cnt;
        if (clr) begin
            cntNext = '0;
        end else if (step) begin
            cntNext = atEnd ? '0 : cnt + W'(1);
        end
    end

    assign syncNext = inWindow(cntNext, syncStart, syncEnd);
    assign actNext  = inWindow(cntNext, actStart, actEnd);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cntNext;
        end
    end
endmodule

// File: rtl/tpg_timing_ctrl.sv
// Video timing sequencer: start/stop scheduler with a frame-synchronous
// double-buffered timing config feeding the horizontal and vertical axes.
module tpg_timing_ctrl
    import tpg_pkg::*;
#(
    parameter int H_BITS = TPG_H_BITS,
    parameter int V_BITS = TPG_V_BITS
) (
    input  logic             clk,
    input  logic             rst,
    tpg_timing_ctrl_if.slave bus
);
    localparam int HW = 5 * H_BITS;
    localparam int VW = 5 * V_BITS;

    tpg_state_e        state;
    tpg_state_e        stateNext;
    logic [HW-1:0]     pendH;
    logic [HW-1:0]     actH;
    logic [HW-1:0]     nextH;
    logic [VW-1:0]     pendV;
    logic [VW-1:0]     actV;
    logic [VW-1:0]     nextV;
    logic              pendValid;
    logic              cfgLoaded;
    logic              accept;
    logic              running;
    logic              live;
    logic              frameWrap;
    logic              doCopy;
    logic              hAtEnd;
    logic              vAtEnd;
    logic              hSyncN;
    logic              vSyncN;
    logic              hActN;
    logic              vActN;
    logic [H_BITS-1:0] xCnt;
    logic [H_BITS-1:0] xNext;
    logic [V_BITS-1:0] yCnt;
    logic [V_BITS-1:0] yNext;
    logic              hsP1;
    logic              vsP1;
    logic              deP1;
    logic              sofP1;
    logic              eolP1;

    function automatic logic [H_BITS-1:0] hField(input logic [HW-1:0] w, input int idx);
        return w[idx*H_BITS +: H_BITS];
    endfunction

    function automatic logic [V_BITS-1:0] vField(input logic [VW-1:0] w, input int idx);
        return w[idx*V_BITS +: V_BITS];
    endfunction

    assign accept    = bus.cfg_valid && !pendValid;
    assign running   = (state != IDLE);
    assign frameWrap = running && hAtEnd && vAtEnd;
    // A word accepted on the wrap edge is not yet pending, so it waits a frame.
    assign doCopy    = pendValid && ((state == IDLE) || frameWrap);
    // Compares look at the config that will govern the next presented pixel.
    assign nextH     = doCopy ? pendH : actH;
    assign nextV     = doCopy ? pendV : actV;
    assign live      = (stateNext != IDLE);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:      if (bus.enable && cfgLoaded && !pendValid) stateNext = RUN;
            RUN:       if (!bus.enable) stateNext = STOP_PEND;
            STOP_PEND: if (frameWrap) stateNext = bus.enable ? RUN : IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    tpg_axis_cnt #(.W(H_BITS)) uHAxis (
        .clk       (clk),
        .rst       (rst),
        .clr       (!live),
        .step      (running),
        .endCur    (hField(actH, FLD_END)),
        .syncStart (hField(nextH, FLD_SYNC_START)),
        .syncEnd   (hField(nextH, FLD_SYNC_END)),
        .actStart  (hField(nextH, FLD_ACT_START)),
        .actEnd    (hField(nextH, FLD_ACT_END)),
        .cnt       (xCnt),
        .cntNext   (xNext),
        .atEnd     (hAtEnd),
        .syncNext  (hSyncN),
        .actNext   (hActN)
    );

    tpg_axis_cnt #(.W(V_BITS)) uVAxis (
        .clk       (clk),
        .rst       (rst),
        .clr       (!live),
        .step      (running && hAtEnd),
        .endCur    (vField(actV, FLD_END)),
        .syncStart (vField(nextV, FLD_SYNC_START)),
        .syncEnd   (vField(nextV, FLD_SYNC_END)),
        .actStart  (vField(nextV, FLD_ACT_START)),
        .actEnd    (vField(nextV, FLD_ACT_END)),
        .cnt       (yCnt),
        .cntNext   (yNext),
        .atEnd     (vAtEnd),
        .syncNext  (vSyncN),
        .actNext   (vActN)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            pendH <= bus.cfg_h;
            pendV <= bus.cfg_v;
        end
    end

    // Stage boundary: control state, active config and strobes for the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pendValid <= 1'b0;
            cfgLoaded <= 1'b0;
            actH      <= '0;
            actV      <= '0;
            hsP1      <= 1'b0;
            vsP1      <= 1'b0;
            deP1      <= 1'b0;
            sofP1     <= 1'b0;
            eolP1     <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                pendValid <= 1'b1;
            end else if (doCopy) begin
                pendValid <= 1'b0;
            end
            if (doCopy) begin
                actH      <= pendH;
                actV      <= pendV;
                cfgLoaded <= 1'b1;
            end
            hsP1  <= live && hSyncN;
            vsP1  <= live && vSyncN;
            deP1  <= live && hActN && vActN;
            sofP1 <= live && (xNext == '0) && (yNext == '0);
            eolP1 <= live && (xNext == hField(nextH, FLD_END));
        end
    end

    assign bus.cfg_ready = !pendValid;
    assign bus.busy      = running;
    assign bus.x         = xCnt;
    assign bus.y         = yCnt;
    assign bus.hs        = hsP1;
    assign bus.vs        = vsP1;
    assign bus.de        = deP1;
    assign bus.sof       = sofP1;
    assign bus.eol       = eolP1;
endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Scoreboard bench for tpg_timing_ctrl: a frame-level reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_tpg_timing_ctrl;
    import tpg_pkg::*;

    localparam int HB = TPG_H_BITS;
    localparam int VB = TPG_V_BITS;

    typedef struct packed {
        logic          busy;
        logic          rdy;
        logic [HB-1:0] x;
        logic [VB-1:0] y;
        logic          hs;
        logic          vs;
        logic          de;
        logic          sof;
        logic          eol;
    } obs_t;

    typedef struct {
        h_timing_t h;
        v_timing_t v;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;

    tpg_timing_ctrl_if #(.H_BITS(HB), .V_BITS(VB)) bus ();

    tpg_timing_ctrl #(.H_BITS(HB), .V_BITS(VB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nFails  = 0;
    int   cycleNo = 0;
    obs_t expQ[$];

    // Reference model: what the DUT presents after the most recent edge.
    bit   mRun, mStopReq, mPend, mLoaded;
    int   mX, mY;
    cfg_t mAct, mPendCfg;

    function automatic bit inWin(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic cfg_t mkCfg(input int hss, input int hse, input int has, input int hae,
                                   input int he, input int vss, input int vse, input int vas,
                                   input int vae, input int ve);
        cfg_t c;
        c.h.syncStart = TPG_H_BITS'(hss);
        c.h.syncEnd   = TPG_H_BITS'(hse);
        c.h.actStart  = TPG_H_BITS'(has);
        c.h.actEnd    = TPG_H_BITS'(hae);
        c.h.axisEnd   = TPG_H_BITS'(he);
        c.v.syncStart = TPG_V_BITS'(vss);
        c.v.syncEnd   = TPG_V_BITS'(vse);
        c.v.actStart  = TPG_V_BITS'(vas);
        c.v.actEnd    = TPG_V_BITS'(vae);
        c.v.axisEnd   = TPG_V_BITS'(ve);
        return c;
    endfunction

    function automatic cfg_t randCfg();
        return mkCfg(int'($urandom_range(0, 22)), int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 22)), int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 22)), int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 22)), int'($urandom_range(0, 12)));
    endfunction

    function automatic obs_t modelObs();
        obs_t o;
        o      = '0;
        o.busy = mRun;
        o.rdy  = !mPend;
        o.x    = HB'(mX);
        o.y    = VB'(mY);
        if (mRun) begin
            o.hs  = inWin(mX, int'(mAct.h.syncStart), int'(mAct.h.syncEnd));
            o.vs  = inWin(mY, int'(mAct.v.syncStart), int'(mAct.v.syncEnd));
            o.de  = inWin(mX, int'(mAct.h.actStart), int'(mAct.h.actEnd)) &&
                    inWin(mY, int'(mAct.v.actStart), int'(mAct.v.actEnd));
            o.sof = (mX == 0) && (mY == 0);
            o.eol = (mX == int'(mAct.h.axisEnd));
        end
        return o;
    endfunction

    task automatic modelStep(input bit r, input bit en, input bit cv, input cfg_t c);
        bit accept, wrap, copy;
        if (r) begin
            mRun = 0; mStopReq = 0; mPend = 0; mLoaded = 0; mX = 0; mY = 0;
            mAct.h = '0; mAct.v = '0;
        end else begin
            accept = cv && !mPend;
            wrap   = mRun && (mX == int'(mAct.h.axisEnd)) && (mY == int'(mAct.v.axisEnd));
            copy   = mPend && (!mRun || wrap);
            if (!mRun) begin
                if (en && mLoaded && !mPend) begin
                    mRun = 1; mStopReq = 0;
                end
            end else begin
                if (mX == int'(mAct.h.axisEnd)) begin
                    mX = 0;
                    mY = (mY == int'(mAct.v.axisEnd)) ? 0 : mY + 1;
                end else begin
                    mX = mX + 1;
                end
                if (wrap && mStopReq) begin
                    mRun = en; mStopReq = 0;
                end else if (!en) begin
                    mStopReq = 1;
                end
            end
            if (copy) begin
                mAct = mPendCfg; mLoaded = 1; mPend = 0;
            end
            if (accept) begin
                mPendCfg = c; mPend = 1;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, predict the post-edge outputs.
    task automatic tick(input bit r, input bit en, input bit cv, input cfg_t c);
        rst           = r;
        bus.enable    = en;
        bus.cfg_valid = cv;
        bus.cfg_h     = c.h;
        bus.cfg_v     = c.v;
        modelStep(r, en, cv, c);
        expQ.push_back(modelObs());
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                obs_t e, a;
                e      = expQ.pop_front();
                a.busy = bus.busy;  a.rdy = bus.cfg_ready;
                a.x    = bus.x;     a.y   = bus.y;
                a.hs   = bus.hs;    a.vs  = bus.vs;  a.de = bus.de;
                a.sof  = bus.sof;   a.eol = bus.eol;
                nChecks++;
                cycleNo++;
                if (a !== e) begin
                    nFails++;
                    $display("FAIL cycle %0d: got busy=%0b rdy=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b sof=%0b eol=%0b, expected busy=%0b rdy=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b sof=%0b eol=%0b",
                             cycleNo, a.busy, a.rdy, a.x, a.y, a.hs, a.vs, a.de, a.sof, a.eol,
                             e.busy, e.rdy, e.x, e.y, e.hs, e.vs, e.de, e.sof, e.eol);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        cfg_t noCfg, cfgA, cfgB, cfgC;
        int   n, cnt, deCnt, eolCnt, sofCnt, lastX, lastY;
        bit   en, r, cv;

        noCfg = mkCfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfgA  = mkCfg(2, 4, 5, 13, 15, 0, 1, 2, 8, 9);
        cfgB  = mkCfg(1, 2, 2, 6, 7, 0, 1, 2, 8, 9);
        cfgC  = mkCfg(3, 1, 0, 12, 11, 1, 3, 0, 10, 9);

        rst = 1'b1; bus.enable = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_h = '0; bus.cfg_v = '0;
        @(negedge clk);
        repeat (3) tick(1, 0, 0, noCfg);

        cnt = 0;
        repeat (100) begin tick(0, 1, 0, noCfg); cnt += int'(bus.busy); end
        check("no start without config", cnt, 0);

        tick(0, 1, 1, cfgA);
        n = 0;
        while (!bus.busy && n < 10) begin tick(0, 1, 0, noCfg); n++; end
        check("busy within 2 cycles", int'(bus.busy && n <= 2), 1);
        check("sof on first run cycle", int'(bus.sof && bus.x == 0 && bus.y == 0), 1);

        deCnt = int'(bus.de); eolCnt = int'(bus.eol); sofCnt = int'(bus.sof);
        repeat (159) begin
            tick(0, 1, 0, noCfg);
            deCnt += int'(bus.de); eolCnt += int'(bus.eol); sofCnt += int'(bus.sof);
        end
        check("de cycles per frame", deCnt, 48);
        check("eol per frame", eolCnt, 10);
        check("sof per frame", sofCnt, 1);
        tick(0, 1, 0, noCfg);
        check("sof period 160", int'(bus.sof), 1);

        n = 0;
        while (!(mY == 4 && mX == 0) && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        check("reach y=4", int'(n < 400), 1);
        tick(0, 1, 1, cfgB);
        check("cfg_ready drops after accept", int'(bus.cfg_ready), 0);
        n = 0;
        while (!bus.sof && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        check("cfg_ready back after wrap", int'(bus.cfg_ready && bus.sof), 1);
        eolCnt = int'(bus.eol);
        repeat (79) begin tick(0, 1, 0, noCfg); eolCnt += int'(bus.eol); end
        check("eol count with period 8", eolCnt, 10);

        n = 0;
        while (!(mX == 7 && mY == 9) && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        check("reach wrap", int'(n < 400), 1);
        tick(0, 1, 1, cfgC);
        n = 0;
        do begin tick(0, 1, 0, noCfg); n++; end while (!bus.sof && n < 500);
        check("frame after wrap offer keeps old period", n, 80);
        n = 0;
        do begin tick(0, 1, 0, noCfg); n++; end while (!bus.sof && n < 500);
        check("new config period", n, 120);

        n = 0;
        while (!(mY == 3 && mX == 0) && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        lastX = 0; lastY = 0; n = 0;
        while (bus.busy && n < 300) begin
            lastX = int'(bus.x); lastY = int'(bus.y);
            tick(0, 0, 0, noCfg); n++;
        end
        check("stop completes frame x", lastX, 11);
        check("stop completes frame y", lastY, 9);
        repeat (5) tick(0, 0, 0, noCfg);

        n = 0;
        while (!bus.sof && n < 20) begin tick(0, 1, 0, noCfg); n++; end
        check("restart from idle", int'(bus.sof), 1);
        n = 0;
        while (!(mY == 3 && mX == 0) && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        repeat (20) tick(0, 0, 0, noCfg);
        cnt = 0;
        repeat (300) begin tick(0, 1, 0, noCfg); cnt += int'(!bus.busy); end
        check("no idle gap on re-enable", cnt, 0);

        n = 0;
        while (!(mX == 7 && mY == 5) && n < 400) begin tick(0, 1, 0, noCfg); n++; end
        tick(1, 1, 0, noCfg);
        check("reset clears position", int'(bus.x) + int'(bus.y), 0);
        check("reset clears strobes",
              int'(bus.hs) + int'(bus.vs) + int'(bus.de) + int'(bus.sof) + int'(bus.eol), 0);
        check("reset busy/ready", int'({bus.busy, bus.cfg_ready}), 1);
        cnt = 0;
        repeat (50) begin tick(0, 1, 0, noCfg); cnt += int'(bus.busy); end
        check("no restart after reset", cnt, 0);

        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en = !en;
            r  = ($urandom_range(0, 799) == 0);
            cv = ($urandom_range(0, 29) == 0);
            tick(r, en, cv, cv ? randCfg() : noCfg);
        end

        @(posedge clk);
        #2;
        check("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/tpg_timing_ctrl.md
Name: tpg_timing_ctrl

Overview:
Video timing sequencer that drives the test pattern generator.
- Owns the horizontal/vertical pixel counters.
- Generates hs/vs/de strobes and the x/y pixel coordinates.
- Takes new timing configurations through a valid/ready handshake and applies them only at frame boundaries, so a frame is never torn.
- Sits between the register/config interface and the pattern datapath; replaces free-running loop counters with a controllable start/stop scheduler.

Parameters:
H_BITS, 12, width of horizontal timing fields and x counter
V_BITS, 12, width of vertical timing fields and y counter

Ports:
clk  input  1  single clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
enable  input  1  level request to run video timing
cfg_valid  input  1  new timing configuration offered
cfg_ready  output  1  pending slot empty, config can be accepted
cfg_h  input  5*H_BITS  {HS_START, HS_END, HACT_START, HACT_END, H_END}, MSB first
cfg_v  input  5*V_BITS  {VS_START, VS_END, VACT_START, VACT_END, V_END}, MSB first
busy  output  1  state != IDLE
x  output  H_BITS  current horizontal count
y  output  V_BITS  current vertical count
hs  output  1  horizontal sync
vs  output  1  vertical sync
de  output  1  active video
sof  output  1  one-cycle pulse at x==0,y==0 of each frame
eol  output  1  one-cycle pulse at x==H_END

Behaviour:
- Reset: state=IDLE, x=0, y=0, hs=vs=de=sof=eol=0, busy=0, cfg_ready=1, pending slot empty, active config=0, cfg_loaded=0.
- Config handshake: transfer when cfg_valid&&cfg_ready. The word goes into the pending slot and cfg_ready drops the next cycle. cfg_ready returns to 1 the cycle after pending is copied to active.
- Pending→active copy:
  - IDLE: the cycle after acceptance. Sets cfg_loaded=1.
  - RUN/STOP_PEND: on the frame-wrap cycle (x==H_END && y==V_END).
  - A config accepted in the same cycle as a wrap is not applied at that wrap; it waits for the next wrap.
- States:
  - IDLE: x=y=0, outputs low. Go to RUN when enable && cfg_loaded && pending slot empty. Without a loaded config, stay in IDLE even if enable=1.
  - RUN: counters advance every cycle. If enable=0 on any cycle, go to STOP_PEND.
  - STOP_PEND: continue the current frame. On the wrap cycle go to IDLE, or back to RUN if enable has returned to 1. No frame is ever truncated.
- Counters: x increments; at x==H_END, x→0 and y increments; at y==V_END and x==H_END, y→0. The first RUN cycle has x=0,y=0.
- Degenerate configs: H_END==0 makes y advance every cycle. If V_END==0, every line is a wrap.
- Strobe timing:
  - All strobes are registered and aligned with the x/y values presented in the same cycle, i.e. derived from next-count values.
  - Zero latency between x/y and strobes at the outputs.
- Strobe equations:
  - hs = HS_START<=x<HS_END
  - vs = VS_START<=y<VS_END
  - de = (HACT_START<=x<HACT_END) && (VACT_START<=y<VACT_END)
  - If START>=END for a field, that strobe never asserts.
  - Comparisons are unsigned and full width.
- sof and eol are asserted only in RUN/STOP_PEND. All strobes are 0 in IDLE.
- Reset mid-frame: next cycle all outputs are at reset values and the active config is cleared. A new config is required before restarting.

Decomposition:
- Shared package tpg_pkg:
  - state encoding (IDLE, RUN, STOP_PEND)
  - packed timing record types h_timing_t/v_timing_t with field offsets for cfg_h/cfg_v
  - default H_BITS/V_BITS constants
- One natural sub-module: tpg_axis_cnt. One instance for the horizontal axis, one for the vertical. It holds a counter, wrap detection, and the sync and active window compares, parameterised by width.
- The controller FSM and config double-buffer stay in the top level.

Test Plan:
- Reset, cfg H_END=15,HS 2..4,HACT 5..13, V_END=9,VS 0..1,VACT 2..8, then enable=1 → RUN starts, sof at first cycle, eol every 16 cycles, sof every 160 cycles, de high 8 cycles/line on lines 2..7.
- enable=1 with no config accepted → busy stays 0 for 100 cycles. Config accepted → busy=1 within 2 cycles.
- Mid-frame (y=4) offer new cfg H_END=7 → cfg_ready drops. Old period (16) holds until wrap. Next frame eol period is 8. cfg_ready=1 the cycle after the wrap.
- Offer config exactly on a wrap cycle → not applied at that wrap, applied at the following wrap.
- Deassert enable at y=3 → frame completes to x=15,y=9, then IDLE with outputs 0. Reassert during STOP_PEND → no IDLE gap; sof immediately follows the wrap.
- Assert rst at x=7,y=5 → next cycle x=y=0, all strobes 0, busy=0, cfg_ready=1. Re-enable without a new cfg → stays IDLE.
